// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle single-accumulator CPU with a shared
// instruction/data memory reached over a req/ack handshake.
// Instruction word: {op[3:0], M, field[ADDR_W-1:0]}. M=1 selects mem[field]
// as the operand, M=0 selects the sign-extended field as an immediate.
module acc_cpu_core #(
    parameter int          DATA_W   = 16,
    parameter int          SAT_EN   = 0,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-6:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] ac,
    output logic [3:0]        flags,
    output logic [DATA_W-6:0] pc,
    output logic              halted,
    output logic              illegal_op
);

    localparam int ADDR_W = DATA_W - 5;
    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_MUL   = 4'h5;
    localparam logic [3:0] OP_DIV   = 4'h6;
    localparam logic [3:0] OP_BR    = 4'h7;
    localparam logic [3:0] OP_BRZ   = 4'h8;
    localparam logic [3:0] OP_BRN   = 4'h9;
    localparam logic [3:0] OP_AND   = 4'hA;
    localparam logic [3:0] OP_OR    = 4'hB;
    localparam logic [3:0] OP_XOR   = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_EXEC,
        S_STORE,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [DATA_W-1:0]   ac_q, ac_d;
    logic [3:0]          flags_q, flags_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;

    // Instruction fields of the latched instruction
    logic [3:0]          op;
    logic                m_bit;
    logic [ADDR_W-1:0]   field;
    logic [DATA_W-1:0]   operand;

    assign op      = ir_q[DATA_W-1 -: 4];
    assign m_bit   = ir_q[DATA_W-5];
    assign field   = ir_q[ADDR_W-1:0];
    assign operand = m_bit ? opnd_q : {{(DATA_W-ADDR_W){field[ADDR_W-1]}}, field};

    // ALU intermediates
    logic [DATA_W:0]            add_full;
    logic [DATA_W:0]            sub_full;
    logic signed [2*DATA_W-1:0] prod;
    logic                       prod_ovf;
    logic                       div_zero;
    logic                       div_ovf;
    logic signed [DATA_W-1:0]   div_b;
    logic signed [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]          alu_res;
    logic                       alu_c;
    logic                       alu_v;
    logic                       alu_pos;
    logic                       alu_sat_ok;
    logic [3:0]                 alu_flags;

    // Bus signals before reset gating
    logic                       req_c;
    logic                       we_c;
    logic [ADDR_W-1:0]          addr_c;
    logic [DATA_W-1:0]          wdata_c;
    logic                       illegal_c;

    // Arithmetic datapath shared by all EXEC operations
    always_comb begin
        add_full = {1'b0, ac_q} + {1'b0, operand};
        sub_full = {1'b0, ac_q} - {1'b0, operand};
        prod     = $signed({{DATA_W{ac_q[DATA_W-1]}}, ac_q})
                 * $signed({{DATA_W{operand[DATA_W-1]}}, operand});
        // Product fits when the top DATA_W+1 bits are all copies of the sign
        prod_ovf = !((&prod[2*DATA_W-1:DATA_W-1]) || !(|prod[2*DATA_W-1:DATA_W-1]));
        div_zero = (operand == '0);
        div_ovf  = (ac_q == S_MIN) && (&operand);
        // Keep the divider away from the two special cases handled separately
        div_b    = (div_zero || div_ovf) ? DATA_W'(1) : $signed(operand);
        quot     = $signed(ac_q) / div_b;
    end

    // Result and flag selection per opcode, including optional saturation
    always_comb begin
        alu_res    = ac_q;
        alu_c      = flags_q[1];
        alu_v      = flags_q[0];
        alu_pos    = 1'b0;
        alu_sat_ok = 1'b0;
        case (op)
            OP_LOAD: begin
                alu_res = operand;
            end
            OP_ADD: begin
                alu_res    = add_full[DATA_W-1:0];
                alu_c      = add_full[DATA_W];
                alu_v      = (ac_q[DATA_W-1] == operand[DATA_W-1])
                          && (add_full[DATA_W-1] != ac_q[DATA_W-1]);
                alu_pos    = ~ac_q[DATA_W-1];
                alu_sat_ok = 1'b1;
            end
            OP_SUB: begin
                alu_res    = sub_full[DATA_W-1:0];
                alu_c      = sub_full[DATA_W];
                alu_v      = (ac_q[DATA_W-1] != operand[DATA_W-1])
                          && (sub_full[DATA_W-1] != ac_q[DATA_W-1]);
                alu_pos    = ~ac_q[DATA_W-1];
                alu_sat_ok = 1'b1;
            end
            OP_MUL: begin
                alu_res    = prod[DATA_W-1:0];
                alu_c      = 1'b0;
                alu_v      = prod_ovf;
                alu_pos    = ~prod[2*DATA_W-1];
                alu_sat_ok = 1'b1;
            end
            OP_DIV: begin
                alu_c = 1'b0;
                if (div_zero) begin
                    // AC is left untouched; only V signals the fault
                    alu_res = ac_q;
                    alu_v   = 1'b1;
                end else if (div_ovf) begin
                    // MIN / -1 has true result +2^(DATA_W-1)
                    alu_res    = S_MIN;
                    alu_v      = 1'b1;
                    alu_pos    = 1'b1;
                    alu_sat_ok = 1'b1;
                end else begin
                    alu_res    = quot;
                    alu_v      = 1'b0;
                    alu_sat_ok = 1'b1;
                end
            end
            OP_AND: begin
                alu_res = ac_q & operand;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            OP_OR: begin
                alu_res = ac_q | operand;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            OP_XOR: begin
                alu_res = ac_q ^ operand;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            default: begin
                alu_res = ac_q;
            end
        endcase
        if ((SAT_EN != 0) && alu_v && alu_sat_ok) begin
            alu_res = alu_pos ? S_MAX : S_MIN;
        end
        alu_flags = {(alu_res == '0), alu_res[DATA_W-1], alu_c, alu_v};
    end

    // Next-state, datapath updates and bus drive for the control FSM
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        opnd_d    = opnd_q;
        ac_d      = ac_q;
        flags_d   = flags_q;
        pc_d      = pc_q;
        req_c     = 1'b0;
        we_c      = 1'b0;
        addr_c    = '0;
        wdata_c   = '0;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c  = 1'b1;
                addr_c = pc_q;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_NOP: state_d = S_FETCH;
                    OP_BR: begin
                        pc_d    = field;
                        state_d = S_FETCH;
                    end
                    OP_BRZ: begin
                        if (flags_q[3]) pc_d = field;
                        state_d = S_FETCH;
                    end
                    OP_BRN: begin
                        if (flags_q[2]) pc_d = field;
                        state_d = S_FETCH;
                    end
                    OP_HALT:  state_d = S_HALT;
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
                    OP_AND, OP_OR, OP_XOR: begin
                        state_d = m_bit ? S_OPERAND : S_EXEC;
                    end
                    default: begin
                        // Undefined opcodes behave as NOP but are flagged
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_OPERAND: begin
                req_c  = 1'b1;
                addr_c = field;
                if (mem_ack) begin
                    opnd_d  = mem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ac_d    = alu_res;
                flags_d = alu_flags;
                state_d = S_FETCH;
            end
            S_STORE: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                addr_c  = field;
                wdata_c = ac_q;
                if (mem_ack) state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            opnd_q  <= '0;
            ac_q    <= '0;
            flags_q <= '0;
            pc_q    <= RESET_PC_A;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            opnd_q  <= opnd_d;
            ac_q    <= ac_d;
            flags_q <= flags_d;
            pc_q    <= pc_d;
        end
    end

    // The bus is forced idle while rst_n is low so an in-flight transfer is
    // abandoned in the same cycle reset asserts, not at the next edge.
    assign mem_req    = req_c & rst_n;
    assign mem_we     = we_c & rst_n;
    assign mem_addr   = rst_n ? addr_c : '0;
    assign mem_wdata  = rst_n ? wdata_c : '0;
    assign ac         = ac_q;
    assign flags      = flags_q;
    assign pc         = pc_q;
    assign halted     = (state_q == S_HALT);
    assign illegal_op = illegal_c;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed testbench for acc_cpu_core: a wrapping instance (dut0) and a
// saturating instance (dut1) run the same programs from one memory image.
module tb_acc_cpu_core;

    logic        clk;
    logic        rst_n;

    logic        mem_req0, mem_we0, mem_ack0;
    logic [10:0] mem_addr0;
    logic [15:0] mem_wdata0, mem_rdata0;
    logic [15:0] ac0;
    logic [3:0]  flags0;
    logic [10:0] pc0;
    logic        halted0, illegal0;

    logic        mem_req1, mem_we1, mem_ack1;
    logic [10:0] mem_addr1;
    logic [15:0] mem_wdata1, mem_rdata1;
    logic [15:0] ac1;
    logic [3:0]  flags1;
    logic [10:0] pc1;
    logic        halted1, illegal1;

    logic [15:0] mem [0:2047];
    int          wait_cfg;
    int          cnt0, cnt1;

    int          checks;
    int          errors;

    // monitor state (dut0)
    int          ill_count, wr_count, req_after_halt;
    logic [10:0] last_wr_addr, prev_rd;
    logic [15:0] last_wr_data;
    logic        saw_wrap;

    acc_cpu_core #(.DATA_W(16), .SAT_EN(0), .RESET_PC(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .mem_ack(mem_ack0),
        .ac(ac0), .flags(flags0), .pc(pc0), .halted(halted0), .illegal_op(illegal0)
    );

    acc_cpu_core #(.DATA_W(16), .SAT_EN(1), .RESET_PC(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .mem_ack(mem_ack1),
        .ac(ac1), .flags(flags1), .pc(pc1), .halted(halted1), .illegal_op(illegal1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responders: ack after wait_cfg wait states; writes are only logged
    assign mem_ack0   = mem_req0 && (cnt0 >= wait_cfg);
    assign mem_ack1   = mem_req1 && (cnt1 >= wait_cfg);
    assign mem_rdata0 = mem[mem_addr0];
    assign mem_rdata1 = mem[mem_addr1];

    always @(posedge clk) begin
        if (!rst_n || !mem_req0 || mem_ack0) cnt0 <= 0;
        else                                 cnt0 <= cnt0 + 1;
        if (!rst_n || !mem_req1 || mem_ack1) cnt1 <= 0;
        else                                 cnt1 <= cnt1 + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            ill_count      <= 0;
            wr_count       <= 0;
            req_after_halt <= 0;
            last_wr_addr   <= '0;
            last_wr_data   <= '0;
            prev_rd        <= '0;
            saw_wrap       <= 1'b0;
        end else begin
            if (illegal0) ill_count <= ill_count + 1;
            if (halted0 && mem_req0) req_after_halt <= req_after_halt + 1;
            if (mem_req0 && mem_ack0) begin
                if (mem_we0) begin
                    wr_count     <= wr_count + 1;
                    last_wr_addr <= mem_addr0;
                    last_wr_data <= mem_wdata0;
                end else begin
                    if (prev_rd == 11'h7FF && mem_addr0 == 11'h000) saw_wrap <= 1'b1;
                    prev_rd <= mem_addr0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic m, input logic [10:0] f);
        return {op, m, f};
    endfunction

    task automatic clr_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    endtask

    // Reset both cores, release, and run until both have halted
    task automatic run_prog(input string tag, input int budget);
        int n;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!(halted0 && halted1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'd0, halted0 && halted1}, 32'd1);
    endtask

    initial begin
        int n;
        int cyc;
        int req_cnt;
        logic found;
        checks   = 0;
        errors   = 0;
        wait_cfg = 0;
        rst_n    = 1'b0;
        clr_mem();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, mem_req0}, 32'd0);
        check("rst_ac", {16'd0, ac0}, 32'd0);
        check("rst_flags", {28'd0, flags0}, 32'd0);
        check("rst_pc", {21'd0, pc0}, 32'd0);
        check("rst_halted", {31'd0, halted0}, 32'd0);

        // T1: reset asserted while an operand read is stalled
        clr_mem();
        wait_cfg = 2;
        mem[0] = ins(4'h1, 1'b0, 11'h7FD);     // LOAD #-3
        mem[1] = ins(4'h1, 1'b1, 11'h100);     // LOAD [0x100]
        mem[2] = ins(4'hF, 1'b0, 11'h000);     // HALT
        mem[11'h100] = 16'h1234;
        rst_n = 1'b1;
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            @(negedge clk);
            n++;
            if (mem_req0 && mem_addr0 == 11'h100) found = 1'b1;
        end
        check("t1_operand_seen", {31'd0, found}, 32'd1);
        check("t1_pc_pre", {21'd0, pc0}, 32'd2);
        check("t1_ac_pre", {16'd0, ac0}, 32'h0000FFFD);
        #2 rst_n = 1'b0;
        #1;
        check("t1_req_drop", {31'd0, mem_req0}, 32'd0);
        check("t1_ac", {16'd0, ac0}, 32'd0);
        check("t1_flags", {28'd0, flags0}, 32'd0);
        check("t1_pc", {21'd0, pc0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t1_refetch_req", {31'd0, mem_req0}, 32'd1);
        check("t1_refetch_addr", {21'd0, mem_addr0}, 32'd0);

        // T2: three wait states on fetch; LOAD #5 takes six cycles
        clr_mem();
        wait_cfg = 3;
        mem[0] = ins(4'h1, 1'b0, 11'd5);
        mem[1] = ins(4'hF, 1'b0, 11'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        req_cnt = (mem_req0 && mem_addr0 == 11'd0 && !mem_we0) ? 1 : 0;
        cyc = 0;
        while (ac0 != 16'd5 && cyc < 30) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (mem_req0 && mem_addr0 == 11'd0 && !mem_we0) req_cnt++;
        end
        check("t2_load_cycles", cyc, 32'd6);
        check("t2_req_cycles", req_cnt, 32'd4);

        // T3: ADD overflow, wrap vs saturate; SUB borrow
        clr_mem();
        wait_cfg = 1;
        mem[0] = ins(4'h1, 1'b1, 11'h100);     // LOAD [0x100] = 0x7FFF
        mem[1] = ins(4'h3, 1'b0, 11'd1);       // ADD #1
        mem[2] = ins(4'hF, 1'b0, 11'd0);
        mem[11'h100] = 16'h7FFF;
        run_prog("t3a", 200);
        check("t3_add_ac", {16'd0, ac0}, 32'h8000);
        check("t3_add_flags", {28'd0, flags0}, 32'h5);
        check("t3_add_sat_ac", {16'd0, ac1}, 32'h7FFF);
        check("t3_add_sat_flags", {28'd0, flags1}, 32'h1);

        clr_mem();
        wait_cfg = 0;
        mem[0] = ins(4'h1, 1'b0, 11'd0);       // LOAD #0
        mem[1] = ins(4'h4, 1'b0, 11'd1);       // SUB #1
        mem[2] = ins(4'hF, 1'b0, 11'd0);
        run_prog("t3b", 200);
        check("t3_sub_ac", {16'd0, ac0}, 32'hFFFF);
        check("t3_sub_flags", {28'd0, flags0}, 32'h6);

        // T4: MUL overflow, DIV truncation, DIV by zero, MIN / -1
        clr_mem();
        mem[0] = ins(4'h1, 1'b0, 11'd300);
        mem[1] = ins(4'h5, 1'b0, 11'd300);
        mem[2] = ins(4'hF, 1'b0, 11'd0);
        run_prog("t4a", 200);
        check("t4_mul_ac", {16'd0, ac0}, 32'h5F90);
        check("t4_mul_flags", {28'd0, flags0}, 32'h1);
        check("t4_mul_sat_ac", {16'd0, ac1}, 32'h7FFF);

        clr_mem();
        mem[0] = ins(4'h1, 1'b0, 11'h7F9);     // LOAD #-7
        mem[1] = ins(4'h6, 1'b0, 11'd2);       // DIV #2
        mem[2] = ins(4'hF, 1'b0, 11'd0);
        run_prog("t4b", 200);
        check("t4_div_ac", {16'd0, ac0}, 32'hFFFD);
        check("t4_div_flags", {28'd0, flags0}, 32'h4);

        clr_mem();
        mem[0] = ins(4'h1, 1'b0, 11'd5);
        mem[1] = ins(4'h6, 1'b0, 11'd0);       // DIV #0
        mem[2] = ins(4'hF, 1'b0, 11'd0);
        run_prog("t4c", 200);
        check("t4_div0_ac", {16'd0, ac0}, 32'h5);
        check("t4_div0_flags", {28'd0, flags0}, 32'h1);
        check("t4_div0_sat_ac", {16'd0, ac1}, 32'h5);

        clr_mem();
        mem[0] = ins(4'h1, 1'b1, 11'h101);     // LOAD [0x101] = 0x8000
        mem[1] = ins(4'h6, 1'b0, 11'h7FF);     // DIV #-1
        mem[2] = ins(4'hF, 1'b0, 11'd0);
        mem[11'h101] = 16'h8000;
        run_prog("t4d", 200);
        check("t4_minneg1_ac", {16'd0, ac0}, 32'h8000);
        check("t4_minneg1_flags", {28'd0, flags0}, 32'h5);
        check("t4_minneg1_sat_ac", {16'd0, ac1}, 32'h7FFF);

        // T5: BRZ taken / not taken, BRN, pc wrap
        clr_mem();
        mem[0] = ins(4'h1, 1'b0, 11'd0);
        mem[1] = ins(4'h8, 1'b0, 11'h020);
        mem[2] = ins(4'h1, 1'b0, 11'd9);
        mem[3] = ins(4'hF, 1'b0, 11'd0);
        mem[11'h20] = ins(4'h1, 1'b0, 11'd7);
        mem[11'h21] = ins(4'hF, 1'b0, 11'd0);
        run_prog("t5a", 200);
        check("t5_brz_taken_ac", {16'd0, ac0}, 32'd7);
        check("t5_brz_taken_pc", {21'd0, pc0}, 32'h22);

        mem[0] = ins(4'h1, 1'b0, 11'd1);
        run_prog("t5b", 200);
        check("t5_brz_not_ac", {16'd0, ac0}, 32'd9);
        check("t5_brz_not_pc", {21'd0, pc0}, 32'd4);

        clr_mem();
        mem[0] = ins(4'h9, 1'b0, 11'h010);     // BRN 0x10 (not taken first pass)
        mem[1] = ins(4'h7, 1'b0, 11'h7FF);     // BR 0x7FF
        mem[11'h7FF] = ins(4'h1, 1'b0, 11'h7FF); // LOAD #-1, then wrap to 0
        mem[11'h010] = ins(4'hF, 1'b0, 11'd0);
        run_prog("t5c", 200);
        check("t5_wrap_ac", {16'd0, ac0}, 32'hFFFF);
        check("t5_wrap_pc", {21'd0, pc0}, 32'h11);
        check("t5_wrap_seen", {31'd0, saw_wrap}, 32'd1);

        // T6: STORE, illegal opcode, HALT
        clr_mem();
        mem[0] = ins(4'h1, 1'b0, 11'd6);
        mem[1] = ins(4'h2, 1'b0, 11'h040);     // STORE 0x40
        mem[2] = ins(4'hF, 1'b0, 11'd0);
        run_prog("t6a", 200);
        check("t6_wr_count", wr_count, 32'd1);
        check("t6_wr_addr", {21'd0, last_wr_addr}, 32'h40);
        check("t6_wr_data", {16'd0, last_wr_data}, 32'd6);
        check("t6_store_flags", {28'd0, flags0}, 32'd0);

        clr_mem();
        mem[0] = ins(4'h1, 1'b0, 11'd8);
        mem[1] = ins(4'hD, 1'b0, 11'd3);       // illegal
        mem[2] = ins(4'hF, 1'b0, 11'd0);
        run_prog("t6b", 200);
        check("t6_illegal_pulses", ill_count, 32'd1);
        check("t6_illegal_ac", {16'd0, ac0}, 32'd8);
        repeat (6) @(negedge clk);
        check("t6_halted", {31'd0, halted0}, 32'd1);
        check("t6_halt_no_req", req_after_halt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
